// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The 2-bit state encodings are also consumed by the pipeline debug bus.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] HZ_ST_RUN      = 2'd0;
  localparam logic [1:0] HZ_ST_LOAD_USE = 2'd1;
  localparam logic [1:0] HZ_ST_FLUSH    = 2'd2;
  localparam logic [1:0] HZ_ST_MEM_WAIT = 2'd3;

  typedef enum logic [1:0] {
    RUN      = HZ_ST_RUN,
    LOAD_USE = HZ_ST_LOAD_USE,
    FLUSH    = HZ_ST_FLUSH,
    MEM_WAIT = HZ_ST_MEM_WAIT
  } hz_state_t;

  // Resolved action for the current cycle, after priority and state masking.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_BUBBLE,
    ACT_FLUSH,
    ACT_FREEZE
  } hz_action_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard inputs and stage controls.
// Performance counters exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W_DEF,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic                  id_ex_mem_read;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_write;
  logic                  id_ex_flush;
  logic                  ex_mem_write;
  logic                  mem_wb_bubble;
  logic [1:0]            hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;
`endif

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_bubble, hz_state
`ifdef HAZARD_PERF_CNT_EN
   ,input  stall_cycles, flush_events
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, id_ex_mem_read, id_ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_bubble, hz_state
`ifdef HAZARD_PERF_CNT_EN
   ,output stall_cycles, flush_events
`endif
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-flush / memory-wait sequencer for the 5-stage pipeline.
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);
  hz_state_t  state_q, state_d;
  hz_action_t act;
  logic       memstall, loaduse, branch;

  assign memstall = hz.mem_req && !hz.mem_ready;
  assign branch   = hz.ex_branch_taken;
  assign loaduse  = hz.id_ex_mem_read && (hz.id_ex_rd != '0) &&
                    ((hz.id_ex_rd == hz.id_rs1) ||
                     (hz.id_uses_rs2 && (hz.id_ex_rd == hz.id_rs2)));

  // Priority memstall > branch > loaduse, with per-state masking.
  always_comb begin
    // NOTE: default first so every path assigns act and no latch is inferred.
    act = ACT_NONE;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (memstall || (state_q == MEM_WAIT && !hz.mem_ready)) act = ACT_FREEZE;
        else if (branch)                                        act = ACT_FLUSH;
        else if (loaduse)                                       act = ACT_BUBBLE;
      end
      LOAD_USE: begin
        if (memstall)    act = ACT_FREEZE;
        else if (branch) act = ACT_FLUSH;
      end
      FLUSH: begin
        if (memstall) act = ACT_FREEZE;
      end
      default: act = ACT_NONE;
    endcase
  end

  always_comb begin
    unique case (act)
      ACT_FREEZE: state_d = MEM_WAIT;
      ACT_FLUSH:  state_d = FLUSH;
      ACT_BUBBLE: state_d = LOAD_USE;
      default:    state_d = RUN;
    endcase
  end

  // NOTE: async reset in the sensitivity list; sequential state uses <= only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    hz.pc_write      = 1'b1;
    hz.if_id_write   = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_write   = 1'b1;
    hz.id_ex_flush   = 1'b0;
    hz.ex_mem_write  = 1'b1;
    hz.mem_wb_bubble = 1'b0;
    hz.hz_state      = state_q;
    if (reset) begin
      hz.pc_write      = 1'b0;
      hz.if_id_write   = 1'b0;
      hz.if_id_flush   = 1'b1;
      hz.id_ex_write   = 1'b0;
      hz.id_ex_flush   = 1'b1;
      hz.ex_mem_write  = 1'b0;
      hz.mem_wb_bubble = 1'b1;
      hz.hz_state      = HZ_ST_RUN;
    end else begin
      unique case (act)
        ACT_FREEZE: begin
          hz.pc_write      = 1'b0;
          hz.if_id_write   = 1'b0;
          hz.id_ex_write   = 1'b0;
          hz.ex_mem_write  = 1'b0;
          hz.mem_wb_bubble = 1'b1;
        end
        ACT_FLUSH: begin
          hz.if_id_flush = 1'b1;
          hz.id_ex_flush = 1'b1;
        end
        ACT_BUBBLE: begin
          hz.pc_write    = 1'b0;
          hz.if_id_write = 1'b0;
          hz.id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_en, flush_en;
  assign stall_en = !reset && !hz.pc_write;
  assign flush_en = !reset && hz.if_id_flush;

  hazard_sat_counter #(.CNT_W($bits(hz.stall_cycles))) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (stall_en),
    .count_o (hz.stall_cycles)
  );

  hazard_sat_counter #(.CNT_W($bits(hz.flush_events))) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (flush_en),
    .count_o (hz.flush_events)
  );
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sequences the pipeline registers and PC around the forwarding unit. It handles three cases: load-use stalls (which forwarding cannot cover), taken-branch flushes resolved in EX, and multi-cycle data-memory waits signalled by a ready handshake. It drives the write enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from a small registered FSM.

## Interface
- REG_ADDR_W, 5, register index width
- CNT_W, 32, performance counter width (used only with HAZARD_PERF_CNT_EN)

- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high
- id_rs1  input  REG_ADDR_W  rs1 of instruction in IF/ID
- id_rs2  input  REG_ADDR_W  rs2 of instruction in IF/ID
- id_uses_rs2  input  1  IF/ID instruction reads rs2
- id_ex_mem_read  input  1  instruction in ID/EX is a load
- id_ex_rd  input  REG_ADDR_W  rd of instruction in ID/EX
- ex_branch_taken  input  1  branch/jump in EX resolved taken
- mem_req  input  1  EX/MEM holds a load or store
- mem_ready  input  1  data memory completes the access this cycle
- pc_write  output  1  PC register enable
- if_id_write  output  1  IF/ID enable
- if_id_flush  output  1  IF/ID loads NOP
- id_ex_write  output  1  ID/EX enable
- id_ex_flush  output  1  ID/EX loads bubble
- ex_mem_write  output  1  EX/MEM enable
- mem_wb_bubble  output  1  MEM/WB loads bubble
- hz_state  output  2  current FSM state (debug)
- stall_cycles, flush_events  output  CNT_W  only with HAZARD_PERF_CNT_EN

## Operation
- States: RUN=0, LOAD_USE=1, FLUSH=2, MEM_WAIT=3.
- Default outputs are all enables 1, all flush/bubble 0.
- Conditions:
  - memstall = mem_req && !mem_ready
  - loaduse = id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==id_rs1 || (id_uses_rs2 && id_ex_rd==id_rs2))
- Priority is memstall > ex_branch_taken > loaduse. It is evaluated in RUN, and in MEM_WAIT once mem_ready=1.
- memstall:
  - Drives pc_write, if_id_write, id_ex_write and ex_mem_write to 0, and mem_wb_bubble to 1.
  - Next state is MEM_WAIT.
- ex_branch_taken:
  - Drives if_id_flush=1 and id_ex_flush=1; pc_write=1 (PC loads the target).
  - Next state is FLUSH. A pending loaduse is discarded because it is a wrong-path instruction.
- loaduse:
  - Drives pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next state is LOAD_USE.
- LOAD_USE:
  - loaduse is masked for exactly one cycle, so only one bubble is inserted.
  - memstall and branch are still honoured.
  - Then returns to RUN.
- FLUSH:
  - ex_branch_taken and loaduse are masked for one cycle (EX holds the bubble).
  - memstall is still honoured.
  - Then returns to RUN.
- MEM_WAIT:
  - While mem_ready=0, the freeze outputs hold.
  - On mem_ready=1, the freeze is released in the same cycle and the priority rules apply.
  - A branch held in the frozen EX stage is acted on at release, not before.

## Timing
- Outputs are combinational from the registered state plus current inputs, so a stall takes effect in the cycle it is detected.
- The state register updates on the rising clk edge.
- Stall latency:
  - Load-use costs exactly 1 bubble cycle.
  - A taken branch costs 2 flushed slots in one cycle.
  - A memory wait costs N freeze cycles, where N is the number of mem_ready=0 cycles with mem_req=1.
- While reset=1:
  - State is RUN.
  - pc_write, if_id_write, id_ex_write and ex_mem_write are 0.
  - if_id_flush, id_ex_flush and mem_wb_bubble are 1.
  - hz_state is 0; counters are 0.
  - Deassertion resumes in RUN with default outputs.
- Reset mid-MEM_WAIT aborts the wait immediately; no outstanding state is retained.
- mem_req with mem_ready=1 in the same cycle is not a stall.
- Branch and loaduse in the same cycle: only the flush is applied.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_write=0 outside reset.
  - flush_events increments on every cycle with if_id_flush=1 outside reset.
  - Both counters saturate at all-ones.
- Undefined: the counter ports and logic are absent, and the remaining behaviour is identical.

## Structure
- hazard_pkg holds:
  - the hz_state_t enum (RUN, LOAD_USE, FLUSH, MEM_WAIT)
  - the REG_ADDR_W default
  - the 2-bit state encoding constants, shared with the pipeline debug bus
- Sub-module hazard_sat_counter (CNT_W-wide, enable, async reset, saturating) is instantiated twice under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs1=5 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle hz_state=1 with default outputs; then RUN.
- rd=x0: id_ex_rd=0, id_rs1=0, id_ex_mem_read=1 → no stall, pc_write=1.
- Branch plus load-use in the same cycle → if_id_flush=1, id_ex_flush=1, pc_write=1; next state FLUSH; ex_branch_taken=1 in FLUSH is ignored.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → 3 cycles of pc_write=0, ex_mem_write=0, mem_wb_bubble=1; release on cycle 4; stall_cycles=3 with the macro defined.
- Reset asserted during MEM_WAIT → outputs immediately at reset values; after deassertion hz_state=0 and pc_write=1.
- Counter saturation with CNT_W=4: 20 stall cycles → stall_cycles=15.
